fwd_ctrl: RTL and testbench
===========================

Name: fwd_ctrl

Overview:
- Resolves RAW hazards by bypassing, which is the counterpart to the load-use stall produced by the hazard detection unit (hdu).
- Tracks in-flight register writers through EX/MEM/WB in an internal shadow pipeline.
- Produces registered operand-forwarding selects for the EX-stage ALU muxes.
- Cross-checks that every load-use hazard it detects is met by an hdu stall on the following cycle.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 16, width of the forward-event counter.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  a valid instruction sits in decode.
- id_rs1  in  REG_W  decode source register 1.
- id_rs2  in  REG_W  decode source register 2.
- id_wr_reg  in  REG_W+1  decode destination; bit[REG_W] is the write enable, bits[REG_W-1:0] are the index.
- id_memrd  in  1  the decode instruction is a load.
- hdu_stall  in  1  stall from the hazard unit; holds decode and injects a bubble into EX.
- flush  in  1  branch/redirect flush; kills the decode and EX shadow entries.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM result.
- fwd_b  out  2  EX operand B select, same encoding.
- lu_err  out  1  sticky flag: a load-use hazard was detected but no stall followed.
- fwd_cnt  out  CNT_W  count of non-zero forward selects issued, saturating.

Behaviour:
- Reset values (async, rst_n=0):
  - All shadow entries invalid.
  - fwd_a=fwd_b=00, lu_err=0, fwd_cnt=0.
- Shadow pipeline:
  - Three entries: EX, MEM, WB. Each holds {valid, wen, idx, memrd}.
  - Each edge: WB<=MEM, MEM<=EX.
  - EX<=decode fields when id_valid && !hdu_stall && !flush; otherwise EX<=bubble (valid=0).
- Forward selects (registered, 1-cycle latency; they describe the instruction entering EX at this edge):
  - Computed only when the decode instruction advances (id_valid && !hdu_stall && !flush); otherwise 00.
  - For rs1 → fwd_a:
    - If the current EX entry is valid, wen=1, idx==rs1, idx!=0 and memrd=0 → 10. That entry will be in MEM next cycle.
    - Else if the current MEM entry is valid, wen=1, idx==rs1 and idx!=0 → 01. That entry will be in WB next cycle.
    - Else 00.
  - rs2 → fwd_b uses the identical rule.
  - Nearest producer wins when both EX and MEM match.
  - Register 0 is never forwarded.
  - A loaded EX entry is never forwarded from MEM; that case is a load-use hazard.
- Load-use check:
  - lu_pend is set at an edge where id_valid, the EX entry is valid with memrd=1 and wen=1, idx!=0, and idx matches rs1 or rs2.
  - On the next edge, if lu_pend=1 and hdu_stall=0, lu_err<=1.
  - lu_err clears only on reset.
  - flush asserted in the checking cycle suppresses the error.
- fwd_cnt:
  - Increments by 1 at each edge where the newly registered fwd_a or fwd_b is non-zero. Increment is 1 even if both are non-zero.
  - Saturates at all-ones with no wrap.
- Simultaneous events:
  - flush dominates hdu_stall: EX gets a bubble, selects go to 00, lu_pend is cleared.
  - A stall with a pending load: the bubble enters EX, and the load moves to MEM.
  - The decode instruction re-evaluates next cycle and then gets 01, since the load is in WB by the time it reaches EX.
- Reset mid-operation: all entries invalidate immediately. No forwarding is issued until new instructions flow.

Decomposition:
- Shared package pipe_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_W.
  - Shadow-entry struct/field offsets.
- One natural sub-module, fwd_match: compares one source index against the EX/MEM entries and returns a 2-bit select plus a load-use hit. Instantiated twice, for rs1 and rs2.

Test Plan:
1. Back-to-back ALU: add x5 then sub x6,x5,x1, no stall → fwd_a=10 one cycle after the sub leaves decode; fwd_b=00; fwd_cnt=1.
2. Distance-2: add x7, nop, or x8,x2,x7 → fwd_b=01 and fwd_a=00 when the or enters EX.
3. Priority: add x3 then add x3 then use x3 → fwd=10, not 01.
4. Load-use with hdu_stall=1 the next cycle:
   - Setup: lw x9, followed by add x4,x9,x9.
   - One bubble; then fwd_a=fwd_b=01 and lu_err stays 0.
   - The same sequence with hdu_stall held 0 → lu_err=1 and it remains set.
5. x0 and flush:
   - Writer to x0 followed by a reader of x0 → selects stay 00.
   - flush together with hdu_stall → EX is a bubble, selects are 00, no lu_err.
6. Counter saturation with CNT_W=4: 20 consecutive forwarding pairs → fwd_cnt=15. Asserting rst_n=0 mid-stream immediately gives fwd_cnt=0, lu_err=0, selects 00.

Source files
------------

// File: rtl/pipe_pkg.sv
// Types shared by the forwarding controller: select encoding and the shadow
// pipeline entry that tracks one in-flight register writer.
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [REG_W-1:0] idx;
        logic             memrd;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    // Destination field layout: bit[REG_W] is the write enable, the rest the index.
    function automatic shadow_t decode_entry(input logic [REG_W:0] wr_reg,
                                             input logic           is_load);
        shadow_t e;
        e.valid = 1'b1;
        e.wen   = wr_reg[REG_W];
        e.idx   = wr_reg[REG_W-1:0];
        e.memrd = is_load;
        return e;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one source register against the EX and MEM writers and returns the
// operand select for it plus a load-use hit.
module fwd_match
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  shadow_t          ex,
    input  logic             mem_valid,
    input  logic             mem_wen,
    input  logic [REG_W-1:0] mem_idx,
    output fwd_sel_e         sel,
    output logic             lu_hit
);

    logic ex_hit;
    logic mem_hit;

    // NOTE: blocking assignments here; every output gets a default first so no latch is inferred.
    always_comb begin
        ex_hit  = ex.valid && ex.wen && (ex.idx == rs) && (ex.idx != '0);
        mem_hit = mem_valid && mem_wen && (mem_idx == rs) && (mem_idx != '0);
        sel     = FWD_RF;
        lu_hit  = ex_hit && ex.memrd;
        // A load in EX has no result yet, so it yields to the older MEM writer.
        if (ex_hit && !ex.memrd) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Operand-forwarding controller: shadows in-flight writers and registers the
// EX-stage mux selects; flags load-use hazards that slipped past the hdu.
module fwd_ctrl #(
    parameter int REG_W = pipe_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W:0]   id_wr_reg,
    input  logic             id_memrd,
    input  logic             hdu_stall,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             lu_err,
    output logic [CNT_W-1:0] fwd_cnt
);

    import pipe_pkg::*;

    // The WB slot is implicit: a MEM writer is selected as 01 because it sits
    // in WB by the time its consumer is in EX, so nothing reads it later.
    shadow_t          ex_q, ex_d;
    shadow_t          mem_q, mem_d;
    fwd_sel_e         fwd_a_q, fwd_a_d;
    fwd_sel_e         fwd_b_q, fwd_b_d;
    fwd_sel_e         sel_a, sel_b;
    logic             hit_a, hit_b;
    logic             advance;
    logic             lu_pend_q, lu_pend_d;
    logic             lu_err_q, lu_err_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

    fwd_match u_match_a (
        .rs        (id_rs1),
        .ex        (ex_q),
        .mem_valid (mem_q.valid),
        .mem_wen   (mem_q.wen),
        .mem_idx   (mem_q.idx),
        .sel       (sel_a),
        .lu_hit    (hit_a)
    );

    fwd_match u_match_b (
        .rs        (id_rs2),
        .ex        (ex_q),
        .mem_valid (mem_q.valid),
        .mem_wen   (mem_q.wen),
        .mem_idx   (mem_q.idx),
        .sel       (sel_b),
        .lu_hit    (hit_b)
    );

    always_comb begin
        advance = id_valid && !hdu_stall && !flush;
        ex_d    = advance ? decode_entry(id_wr_reg, id_memrd) : BUBBLE;
        mem_d   = ex_q;
        fwd_a_d = advance ? sel_a : FWD_RF;
        fwd_b_d = advance ? sel_b : FWD_RF;
        // Pending means the consumer of a load left decode without a stall.
        lu_pend_d = advance && (hit_a || hit_b);
        lu_err_d  = lu_err_q || (lu_pend_q && !flush);
        fwd_cnt_d = fwd_cnt_q;
        if (((fwd_a_d != FWD_RF) || (fwd_b_d != FWD_RF)) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= BUBBLE;
            mem_q     <= BUBBLE;
            fwd_a_q   <= FWD_RF;
            fwd_b_q   <= FWD_RF;
            lu_pend_q <= 1'b0;
            lu_err_q  <= 1'b0;
            fwd_cnt_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
            lu_pend_q <= lu_pend_d;
            lu_err_q  <= lu_err_d;
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    assign fwd_a   = fwd_a_q;
    assign fwd_b   = fwd_b_q;
    assign lu_err  = lu_err_q;
    assign fwd_cnt = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed-vector bench for fwd_ctrl with a narrow counter so saturation is
// reachable; every expected value is worked out by hand from the sequence.
module tb_fwd_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W:0]   id_wr_reg;
    logic             id_memrd;
    logic             hdu_stall;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             lu_err;
    logic [CNT_W-1:0] fwd_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_wr_reg (id_wr_reg),
        .id_memrd  (id_memrd),
        .hdu_stall (hdu_stall),
        .flush     (flush),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .lu_err    (lu_err),
        .fwd_cnt   (fwd_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REG_W:0] wr(input logic [REG_W-1:0] idx);
        return {1'b1, idx};
    endfunction

    // Present one decode slot, clock it in, and settle 1 ns after the edge.
    task automatic issue(input logic v, input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
                         input logic [REG_W:0] wreg, input logic mr, input logic st, input logic fl);
        id_valid  = v;
        id_rs1    = r1;
        id_rs2    = r2;
        id_wr_reg = wreg;
        id_memrd  = mr;
        hdu_stall = st;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic fl);
        issue(1'b0, '0, '0, '0, 1'b0, 1'b0, fl);
    endtask

    initial begin
        int exp_cnt;
        rst_n     = 1'b0;
        id_valid  = 1'b0;
        id_rs1    = '0;
        id_rs2    = '0;
        id_wr_reg = '0;
        id_memrd  = 1'b0;
        hdu_stall = 1'b0;
        flush     = 1'b0;
        #12;
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_fwd_b", 32'(fwd_b), 32'd0);
        check("rst_lu_err", 32'(lu_err), 32'd0);
        check("rst_cnt", 32'(fwd_cnt), 32'd0);
        rst_n = 1'b1;

        // Back-to-back ALU: add x5 ; sub x6,x5,x1
        issue(1'b1, 5'd1, 5'd2, wr(5'd5), 1'b0, 1'b0, 1'b0);
        issue(1'b1, 5'd5, 5'd1, wr(5'd6), 1'b0, 1'b0, 1'b0);
        check("b2b_fwd_a", 32'(fwd_a), 32'd2);
        check("b2b_fwd_b", 32'(fwd_b), 32'd0);
        check("b2b_cnt", 32'(fwd_cnt), 32'd1);

        // Distance two: add x7 ; nop ; or x8,x2,x7
        issue(1'b1, 5'd3, 5'd4, wr(5'd7), 1'b0, 1'b0, 1'b0);
        check("d2_first_a", 32'(fwd_a), 32'd0);
        nop(1'b0);
        issue(1'b1, 5'd2, 5'd7, wr(5'd8), 1'b0, 1'b0, 1'b0);
        check("d2_fwd_a", 32'(fwd_a), 32'd0);
        check("d2_fwd_b", 32'(fwd_b), 32'd1);
        check("d2_cnt", 32'(fwd_cnt), 32'd2);

        // Priority: two writers of x3, then a reader of x3 on both operands
        issue(1'b1, 5'd1, 5'd2, wr(5'd3), 1'b0, 1'b0, 1'b0);
        issue(1'b1, 5'd10, 5'd11, wr(5'd3), 1'b0, 1'b0, 1'b0);
        issue(1'b1, 5'd3, 5'd3, wr(5'd12), 1'b0, 1'b0, 1'b0);
        check("prio_fwd_a", 32'(fwd_a), 32'd2);
        check("prio_fwd_b", 32'(fwd_b), 32'd2);
        check("prio_cnt", 32'(fwd_cnt), 32'd3);

        // Load-use met by a stall: lw x9 ; add x4,x9,x9 (stalled once)
        issue(1'b1, 5'd2, 5'd0, wr(5'd9), 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5'd9, 5'd9, wr(5'd4), 1'b0, 1'b1, 1'b0);
        check("lu_stall_bubble_a", 32'(fwd_a), 32'd0);
        issue(1'b1, 5'd9, 5'd9, wr(5'd4), 1'b0, 1'b0, 1'b0);
        check("lu_stall_fwd_a", 32'(fwd_a), 32'd1);
        check("lu_stall_fwd_b", 32'(fwd_b), 32'd1);
        check("lu_stall_cnt", 32'(fwd_cnt), 32'd4);
        nop(1'b0);
        check("lu_stall_no_err", 32'(lu_err), 32'd0);

        // x0 is never forwarded
        issue(1'b1, 5'd1, 5'd0, wr(5'd0), 1'b0, 1'b0, 1'b0);
        issue(1'b1, 5'd0, 5'd0, wr(5'd13), 1'b0, 1'b0, 1'b0);
        check("x0_fwd_a", 32'(fwd_a), 32'd0);
        check("x0_fwd_b", 32'(fwd_b), 32'd0);
        check("x0_cnt", 32'(fwd_cnt), 32'd4);

        // flush together with stall on a load-use consumer
        issue(1'b1, 5'd1, 5'd2, wr(5'd9), 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5'd9, 5'd9, wr(5'd4), 1'b0, 1'b1, 1'b1);
        check("flush_fwd_a", 32'(fwd_a), 32'd0);
        check("flush_fwd_b", 32'(fwd_b), 32'd0);
        nop(1'b0);
        check("flush_no_err", 32'(lu_err), 32'd0);

        // Unstalled load-use whose checking cycle is flushed
        issue(1'b1, 5'd1, 5'd0, wr(5'd9), 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5'd9, 5'd9, wr(5'd4), 1'b0, 1'b0, 1'b0);
        check("lu_load_not_fwd", 32'(fwd_a), 32'd0);
        nop(1'b1);
        check("lu_flush_suppress", 32'(lu_err), 32'd0);

        // Unstalled load-use: error raised and sticky
        issue(1'b1, 5'd1, 5'd0, wr(5'd9), 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5'd9, 5'd9, wr(5'd4), 1'b0, 1'b0, 1'b0);
        check("lu_nostall_pre", 32'(lu_err), 32'd0);
        nop(1'b0);
        check("lu_nostall_err", 32'(lu_err), 32'd1);
        nop(1'b0);
        check("lu_err_sticky", 32'(lu_err), 32'd1);
        check("lu_cnt", 32'(fwd_cnt), 32'd4);

        // Saturation: 20 forwarding pairs on a 4-bit counter
        exp_cnt = 4;
        for (int i = 0; i < 20; i++) begin
            issue(1'b1, 5'd1, 5'd2, wr(5'd5), 1'b0, 1'b0, 1'b0);
            issue(1'b1, 5'd5, 5'd1, wr(5'd6), 1'b0, 1'b0, 1'b0);
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            check($sformatf("sat_cnt_%0d", i), 32'(fwd_cnt), 32'(exp_cnt));
        end
        check("sat_fwd_a", 32'(fwd_a), 32'd2);

        // Asynchronous reset mid-stream, away from the clock edge
        id_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_fwd_a", 32'(fwd_a), 32'd0);
        check("mid_rst_fwd_b", 32'(fwd_b), 32'd0);
        check("mid_rst_lu_err", 32'(lu_err), 32'd0);
        check("mid_rst_cnt", 32'(fwd_cnt), 32'd0);
        #2 rst_n = 1'b1;
        issue(1'b1, 5'd5, 5'd1, wr(5'd6), 1'b0, 1'b0, 1'b0);
        check("post_rst_fwd_a", 32'(fwd_a), 32'd0);
        check("post_rst_cnt", 32'(fwd_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
